score_bcd_keeper: RTL

- Upstream feeder of the 3-digit seven-segment display stage.
- Holds the live game score and the best score as 3-digit BCD, range 000–999.
- Accepts point-add, clear and game-over pulses from game logic.
- Generates the 2-bit digit scan select, and drives the three digit codes for the display stage.

---
 rtl/score_bcd_keeper_if.sv | 24 ++
 rtl/score_bcd_keeper.sv | 124 ++++++++++++
 2 files changed

// File: rtl/score_bcd_keeper_if.sv
// Control and display-digit bundle between game logic, the score keeper and the display stage.
interface score_bcd_keeper_if;
    logic       add_en;
    logic [3:0] add_val;
    logic       clear;
    logic       game_over;
    logic       show_best;
    logic [1:0] stcl;
    logic [3:0] score0;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       sat;
    logic       new_best;

    modport master (
        output add_en, add_val, clear, game_over, show_best,
        input  stcl, score0, score1, score2, sat, new_best
    );

    modport slave (
        input  add_en, add_val, clear, game_over, show_best,
        output stcl, score0, score1, score2, sat, new_best
    );
endinterface

// File: rtl/score_bcd_keeper.sv
// Live/best 3-digit BCD score keeper with saturation, best-score tracking, digit scan select
// and optional leading-zero blanking for the seven-segment display stage.
module score_bcd_keeper #(
    parameter int unsigned REFRESH_BITS = 17,
    parameter bit          BLANK_LZ     = 1'b1
) (
    input logic                clk,
    input logic                rst,
    score_bcd_keeper_if.slave  bus
);

    logic [REFRESH_BITS-1:0] r_div;
    logic [3:0] r_live0, r_live1, r_live2;
    logic [3:0] r_best0, r_best1, r_best2;
    logic       r_sat;
    logic       r_new_best;

    logic [3:0] w_live0, w_live1, w_live2;
    logic [3:0] w_best0, w_best1, w_best2;
    logic       w_sat;
    logic       w_new_best;

    logic [3:0] w_v;
    logic [4:0] w_s0, w_s1, w_s2;
    logic       w_c0, w_c1, w_c2;
    logic [3:0] w_d0, w_d1, w_d2;
    logic       w_live_gt;
    logic [3:0] w_src0, w_src1, w_src2;

    // BCD ripple add; +6 mod 16 on a carried digit is the same as subtracting 10
    always_comb begin
        w_v  = (bus.add_val > 4'd9) ? 4'd9 : bus.add_val;
        w_s0 = {1'b0, r_live0} + {1'b0, w_v};
        w_c0 = (w_s0 > 5'd9);
        w_d0 = w_c0 ? (w_s0[3:0] + 4'd6) : w_s0[3:0];
        w_s1 = {1'b0, r_live1} + {4'b0, w_c0};
        w_c1 = (w_s1 > 5'd9);
        w_d1 = w_c1 ? (w_s1[3:0] + 4'd6) : w_s1[3:0];
        w_s2 = {1'b0, r_live2} + {4'b0, w_c1};
        w_c2 = (w_s2 > 5'd9);
        w_d2 = w_c2 ? (w_s2[3:0] + 4'd6) : w_s2[3:0];
    end

    assign w_live_gt = ({r_live2, r_live1, r_live0} > {r_best2, r_best1, r_best0});

    always_comb begin
        w_live0    = r_live0;
        w_live1    = r_live1;
        w_live2    = r_live2;
        w_best0    = r_best0;
        w_best1    = r_best1;
        w_best2    = r_best2;
        w_sat      = r_sat;
        w_new_best = 1'b0;

        // Best compares against the pre-update live score, whatever else happens this cycle
        if (bus.game_over && w_live_gt) begin
            w_best0    = r_live0;
            w_best1    = r_live1;
            w_best2    = r_live2;
            w_new_best = 1'b1;
        end

        if (bus.clear) begin
            w_live0 = 4'd0;
            w_live1 = 4'd0;
            w_live2 = 4'd0;
            w_sat   = 1'b0;
        end else if (bus.add_en) begin
            if (w_c2) begin
                w_live0 = 4'd9;
                w_live1 = 4'd9;
                w_live2 = 4'd9;
                w_sat   = 1'b1;
            end else begin
                w_live0 = w_d0;
                w_live1 = w_d1;
                w_live2 = w_d2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div      <= '0;
            r_live0    <= 4'd0;
            r_live1    <= 4'd0;
            r_live2    <= 4'd0;
            r_best0    <= 4'd0;
            r_best1    <= 4'd0;
            r_best2    <= 4'd0;
            r_sat      <= 1'b0;
            r_new_best <= 1'b0;
        end else begin
            r_div      <= r_div + 1'b1;
            r_live0    <= w_live0;
            r_live1    <= w_live1;
            r_live2    <= w_live2;
            r_best0    <= w_best0;
            r_best1    <= w_best1;
            r_best2    <= w_best2;
            r_sat      <= w_sat;
            r_new_best <= w_new_best;
        end
    end

    always_comb begin
        w_src0 = bus.show_best ? r_best0 : r_live0;
        w_src1 = bus.show_best ? r_best1 : r_live1;
        w_src2 = bus.show_best ? r_best2 : r_live2;
    end

    // 4'hF is the display stage's blank code
    always_comb begin
        bus.score0 = w_src0;
        bus.score1 = (BLANK_LZ && (w_src2 == 4'd0) && (w_src1 == 4'd0)) ? 4'hF : w_src1;
        bus.score2 = (BLANK_LZ && (w_src2 == 4'd0)) ? 4'hF : w_src2;
    end

    assign bus.stcl     = r_div[REFRESH_BITS-1 -: 2];
    assign bus.sat      = r_sat;
    assign bus.new_best = r_new_best;

endmodule
